// File: rtl/cache_traffic_checker_if.sv
// cache_traffic_checker_if: CPU-side request/response bus between traffic checker and L1 cache
interface cache_traffic_checker_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_rw;
  logic              req_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  modport master (output req_addr, req_data, req_rw, req_valid, input res_data, res_ready);
  modport slave (input req_addr, req_data, req_rw, req_valid, output res_data, res_ready);
endinterface

// File: rtl/cache_traffic_checker.sv
// cache_traffic_checker: writes a programmed sequence, reads it back and reports mismatches
module cache_traffic_checker #(
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 32,
  parameter int NUM_WORDS    = 16,
  parameter int BASE_ADDR    = 0,
  parameter int STRIDE       = 1,
  parameter int PATTERN      = 0,
  parameter int READ_REVERSE = 0,
  parameter int NUM_PASSES   = 1,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    start,
  cache_traffic_checker_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [15:0]             err_count,
  output logic [ADDR_W-1:0]       first_err_addr,
  output logic                    led
);
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int PW = NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0, WR_REQ = 3'd1, WR_GAP = 3'd2, RD_REQ = 3'd3, RD_GAP = 3'd4, DONE = 3'd5;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
  logic [2:0]        state;
  logic [IW-1:0]     idx, eff;
  logic [PW-1:0]     pcnt;
  logic [TW-1:0]     timer;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pat, exp_data;
  logic              is_req, reading, last_idx, last_pass, expired, mismatch;
  // word address, expected data and phase decode for the current index
  always_comb begin
    is_req    = state == WR_REQ || state == RD_REQ;
    reading   = state == RD_REQ || state == RD_GAP;
    eff       = (READ_REVERSE != 0 && reading) ? LAST - idx : idx;
    addr      = BASE + ADDR_W'(eff) * STEP;
    pat       = PATTERN == 0 ? DATA_W'(addr) : PATTERN == 1 ? ~DATA_W'(addr) : DATA_W'(1) << (eff % DATA_W);
    exp_data  = pat ^ DATA_W'({(DATA_W / 8){8'(pcnt)}});
    last_idx  = idx == LAST;
    last_pass = pcnt == LAST_PASS;
    expired   = timer == TLIM;
    mismatch  = bus.res_data != exp_data;
  end
  assign bus.req_valid = is_req;
  assign bus.req_rw    = state == WR_REQ;
  assign bus.req_addr  = is_req ? addr : '0;
  assign bus.req_data  = state == WR_REQ ? exp_data : '0;
  assign busy          = state != IDLE && state != DONE;
  assign done          = state == DONE;
  assign pass          = done && err_count == '0 && !timeout;
  assign led           = pass;
  // sequencer: request/gap per word, write then read per pass, timeout abort
  always_ff @(posedge sys_clk or negedge rst)
    if (!rst) begin
      state          <= IDLE;
      idx            <= '0;
      pcnt           <= '0;
      timer          <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else if (start && !busy) begin
      state          <= WR_REQ;
      idx            <= '0;
      pcnt           <= '0;
      timer          <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else if (is_req && bus.res_ready) begin
      timer <= '0;
      state <= state == WR_REQ ? WR_GAP : RD_GAP;
      if (state == RD_REQ && mismatch) begin
        err_count <= err_count + 16'(err_count != 16'hFFFF);
        if (err_count == '0) first_err_addr <= addr;
      end
    end else if (is_req) begin
      timer <= timer + 1'b1;
      if (expired) begin
        state   <= DONE;
        timeout <= 1'b1;
      end
    end else if (state == WR_GAP || state == RD_GAP) begin
      idx <= last_idx ? '0 : idx + 1'b1;
      if (state == WR_GAP) state <= last_idx ? RD_REQ : WR_REQ;
      else if (!last_idx) state <= RD_REQ;
      else if (last_pass) state <= DONE;
      else begin
        state <= WR_REQ;
        pcnt  <= pcnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_cache_traffic_checker.sv
// tb_cache_traffic_checker: three configured checkers against a behavioural cache with a reference sequence model
module tb_cache_traffic_checker;
  typedef struct {int g; bit rw; logic [26:0] a; logic [31:0] d;} txn_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] start = '0;
  logic [2:0] busy, done, pass_o, tmo, led, rv, rr, rw;
  logic [2:0][15:0] errc;
  logic [2:0][26:0] fea, ra;
  logic [2:0][31:0] rd;
  logic [2:0] en = '1, noise = '0, stale = '0, fault = '0;
  logic [2:0][26:0] fault_a = '0;
  logic [31:0] mem [logic [28:0]];
  txn_t log_q[$];
  int vecs = 0, miss = 0, cyc, n;
  bit mon_en = 1'b0, hs_d = 1'b0, gap_d = 1'b0;
  always #5 clk = ~clk;
  function automatic int nw(int g); return g == 1 ? 3 : 4; endfunction
  function automatic int base(int g); return g == 1 ? 0 : 'h100; endfunction
  function automatic int stride(int g); return g == 1 ? 'h40 : 1; endfunction
  function automatic int psel(int g); return g == 0 ? 0 : g == 1 ? 2 : 1; endfunction
  function automatic int rev(int g); return g == 1 ? 1 : 0; endfunction
  function automatic int np(int g); return g == 2 ? 2 : 1; endfunction
  function automatic logic [26:0] addr_of(int g, int i); return 27'(base(g) + i * stride(g)); endfunction
  function automatic logic [31:0] dat(int g, int i, int p);
    logic [26:0] a;
    logic [31:0] d;
    logic [7:0] b;
    a = addr_of(g, i);
    b = 8'(p);
    d = psel(g) == 0 ? {5'b0, a} : psel(g) == 1 ? ~{5'b0, a} : 32'(1) << (i % 32);
    return d ^ {4{b}};
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_u
    int cnt = 0, lat = 1;
    logic [28:0] key;
    cache_traffic_checker_if #(.ADDR_W(27), .DATA_W(32)) bif ();
    cache_traffic_checker #(
      .ADDR_W(27), .DATA_W(32), .NUM_WORDS(nw(g)), .BASE_ADDR(base(g)), .STRIDE(stride(g)),
      .PATTERN(psel(g)), .READ_REVERSE(rev(g)), .NUM_PASSES(np(g)), .TIMEOUT(g == 0 ? 64 : 1024)
    ) u_dut (
      .sys_clk(clk), .rst(rst), .start(start[g]), .bus(bif.master),
      .busy(busy[g]), .done(done[g]), .pass(pass_o[g]), .timeout(tmo[g]),
      .err_count(errc[g]), .first_err_addr(fea[g]), .led(led[g])
    );
    assign rv[g] = bif.req_valid;
    assign rr[g] = bif.res_ready;
    assign rw[g] = bif.req_rw;
    assign ra[g] = bif.req_addr;
    assign rd[g] = bif.req_data;
    initial begin
      bif.res_ready = 1'b0;
      bif.res_data  = '0;
      forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
          bif.res_ready = 1'b0;
          cnt = 0;
        end else if (bif.res_ready) begin
          bif.res_ready = 1'b0;
          cnt = 0;
        end else if (bif.req_valid && en[g]) begin
          cnt++;
          if (cnt == 1) lat = $urandom_range(1, 4);
          if (cnt >= lat) begin
            bif.res_ready = 1'b1;
            key = {2'(g), bif.req_addr};
            if (bif.req_rw) begin
              if (!(stale[g] && mem.exists(key))) mem[key] = bif.req_data;
              bif.res_data = $urandom;
              log_q.push_back('{g, 1'b1, bif.req_addr, bif.req_data});
            end else begin
              bif.res_data = (fault[g] && bif.req_addr == fault_a[g]) ? 32'hDEADBEEF : mem.exists(key) ? mem[key] : 32'h0;
              log_q.push_back('{g, 1'b0, bif.req_addr, bif.res_data});
            end
          end
        end else if (!bif.req_valid) bif.res_ready = noise[g] && $urandom_range(0, 3) == 0;
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (mon_en) begin
      if (hs_d && busy[1]) check("gap_low", rv[1], 0);
      if (gap_d && busy[1]) check("gap_high", rv[1], 1);
      gap_d <= hs_d && busy[1];
      hs_d  <= rv[1] && rr[1];
    end
  task automatic pulse(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask
  task automatic run(input int g, input int mid);
    log_q.delete();
    mem.delete();
    pulse(g);
    cyc = 0;
    while (!done[g] && cyc < 2000) begin
      if (cyc == mid) pulse(g);
      else @(negedge clk);
      cyc++;
    end
    check("run_done", done[g], 1);
    check("run_busy", busy[g], 0);
  endtask
  task automatic check_log(input int g);
    int k = 0;
    for (int p = 0; p < np(g); p++) begin
      for (int i = 0; i < nw(g); i++) begin
        if (k < log_q.size()) begin
          check("wr_rw", log_q[k].rw, 1);
          check("wr_addr", log_q[k].a, addr_of(g, i));
          check("wr_data", log_q[k].d, dat(g, i, p));
        end
        k++;
      end
      for (int j = 0; j < nw(g); j++) begin
        int i;
        i = rev(g) != 0 ? nw(g) - 1 - j : j;
        if (k < log_q.size()) begin
          check("rd_rw", log_q[k].rw, 0);
          check("rd_addr", log_q[k].a, addr_of(g, i));
        end
        k++;
      end
    end
    check("log_len", log_q.size(), k);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_flags", {busy, done, pass_o, tmo, led, rv, rw}, 0);
    check("rst_err", errc[0], 0);
    check("rst_fea", fea[0], 0);
    check("rst_addr", ra[0], 0);
    check("rst_data", rd[0], 0);
    rst = 1'b1;
    @(negedge clk);
    noise[0] = 1'b1;
    run(0, -1);
    noise[0] = 1'b0;
    check_log(0);
    check("basic_pass", pass_o[0], 1);
    check("basic_led", led[0], 1);
    check("basic_err", errc[0], 0);
    fault[0]   = 1'b1;
    fault_a[0] = 27'(27'h100 + $urandom_range(0, 3));
    run(0, -1);
    fault[0] = 1'b0;
    check("fault_err", errc[0], 1);
    check("fault_fea", fea[0], fault_a[0]);
    check("fault_pass", pass_o[0], 0);
    check("fault_led", led[0], 0);
    mon_en = 1'b1;
    run(1, -1);
    mon_en = 1'b0;
    check_log(1);
    check("rev_first_rd", log_q.size() > 3 ? log_q[3].a : 27'h7FFFFFF, 27'h80);
    check("rev_pass", pass_o[1], 1);
    run(2, -1);
    check_log(2);
    check("mp_pass1_data", log_q.size() > 8 ? log_q[8].d : 32'h0, 32'hFEFEFFFE);
    check("mp_pass", pass_o[2], 1);
    stale[2] = 1'b1;
    run(2, -1);
    stale[2] = 1'b0;
    check("stale_err", errc[2], 4);
    check("stale_fea", fea[2], 27'h100);
    check("stale_pass", pass_o[2], 0);
    en[0] = 1'b0;
    pulse(0);
    cyc = 0;
    n = 0;
    while (!done[0] && cyc < 200) begin
      if (rv[0]) n++;
      @(negedge clk);
      cyc++;
    end
    en[0] = 1'b1;
    check("to_cycles", n, 64);
    check("to_done", done[0], 1);
    check("to_flag", tmo[0], 1);
    check("to_pass", pass_o[0], 0);
    check("to_busy", busy[0], 0);
    run(0, 5);
    check_log(0);
    check("midstart_pass", pass_o[0], 1);
    check("midstart_to_clear", tmo[0], 0);
    log_q.delete();
    pulse(0);
    cyc = 0;
    while (!(rv[0] && !rw[0]) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rd_req_reached", rv[0] && !rw[0], 1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", rv[0], 0);
    check("arst_busy", busy[0], 0);
    check("arst_addr", ra[0], 0);
    @(negedge clk);
    rst = 1'b1;
    run(0, -1);
    check_log(0);
    check("after_rst_pass", pass_o[0], 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
